// File: rtl/game_turn_controller.sv
// Turn sequencer for one Connect-N round: drops tokens into the grid, waits for
// the Scoreboard verdict, then hands the turn over or closes the round.
module game_turn_controller #(
    parameter int ROWS         = 4,
    parameter int COLS         = 4,
    parameter int COL_W        = 3,
    parameter int CHECK_CYCLES = 2
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     drop_valid,
    input  logic [COL_W-1:0]         drop_col,
    output logic                     drop_ready,
    output logic                     drop_reject,
    input  logic                     new_round,
    input  logic [1:0]               winner,
    output logic [2*ROWS*COLS-1:0]   game_status,
    output logic                     grid_full,
    output logic [1:0]               current_player,
    output logic                     round_over
);

    localparam int GRID_W = 2 * ROWS * COLS;
    localparam int CNT_W  = $clog2(CHECK_CYCLES + 1);

    typedef enum logic [1:0] {
        WAIT_MOVE,
        PLACE,
        CHECK,
        ROUND_OVER
    } state_t;

    state_t            state_q;
    logic [GRID_W-1:0] grid_q;
    logic [GRID_W-1:0] grid_d;
    logic [COL_W-1:0]  col_q;
    logic [CNT_W-1:0]  cnt_q;
    logic [1:0]        player_q;
    logic [1:0]        start_q;
    logic              reject_q;
    logic              full_q;
    logic              over_q;

    logic              col_in_range;
    logic              col_full;
    logic              all_full;
    logic              placed;

    assign col_in_range = int'(drop_col) < COLS;

    always_comb begin
        col_full = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(drop_col) == c) begin
                col_full = grid_q[2*ROWS*c + 2*(ROWS-1) +: 2] != 2'b00;
            end
        end
    end

    // Lowest empty row of the latched column takes the current player's token.
    always_comb begin
        grid_d = grid_q;
        placed = 1'b0;
        for (int c = 0; c < COLS; c++) begin
            if (int'(col_q) == c) begin
                for (int r = 0; r < ROWS; r++) begin
                    if (!placed && grid_q[2*ROWS*c + 2*r +: 2] == 2'b00) begin
                        grid_d[2*ROWS*c + 2*r +: 2] = player_q;
                        placed = 1'b1;
                    end
                end
            end
        end
    end

    always_comb begin
        all_full = 1'b1;
        for (int i = 0; i < ROWS * COLS; i++) begin
            if (grid_q[2*i +: 2] == 2'b00) begin
                all_full = 1'b0;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q  <= WAIT_MOVE;
            grid_q   <= '0;
            col_q    <= '0;
            cnt_q    <= '0;
            player_q <= 2'b01;
            start_q  <= 2'b01;
            reject_q <= 1'b0;
            full_q   <= 1'b0;
            over_q   <= 1'b0;
        end else begin
            reject_q <= 1'b0;
            if (new_round) begin
                state_q  <= WAIT_MOVE;
                grid_q   <= '0;
                full_q   <= 1'b0;
                over_q   <= 1'b0;
                start_q  <= {start_q[0], start_q[1]};
                player_q <= {start_q[0], start_q[1]};
            end else begin
                case (state_q)
                    WAIT_MOVE: begin
                        if (drop_valid) begin
                            if (!col_in_range || col_full) begin
                                reject_q <= 1'b1;
                            end else begin
                                col_q   <= drop_col;
                                state_q <= PLACE;
                            end
                        end
                    end
                    PLACE: begin
                        grid_q  <= grid_d;
                        cnt_q   <= CNT_W'(CHECK_CYCLES);
                        state_q <= CHECK;
                    end
                    CHECK: begin
                        // A win takes precedence so a winning last move never reads as a draw.
                        if (cnt_q > CNT_W'(1)) begin
                            cnt_q <= cnt_q - 1'b1;
                        end else if (winner != 2'b00) begin
                            over_q  <= 1'b1;
                            state_q <= ROUND_OVER;
                        end else if (all_full) begin
                            full_q  <= 1'b1;
                            over_q  <= 1'b1;
                            state_q <= ROUND_OVER;
                        end else begin
                            player_q <= {player_q[0], player_q[1]};
                            state_q  <= WAIT_MOVE;
                        end
                    end
                    ROUND_OVER: begin
                        state_q <= ROUND_OVER;
                    end
                    default: begin
                        state_q <= WAIT_MOVE;
                    end
                endcase
            end
        end
    end

    assign drop_ready     = (state_q == WAIT_MOVE);
    assign drop_reject    = reject_q;
    assign game_status    = grid_q;
    assign grid_full      = full_q;
    assign current_player = player_q;
    assign round_over     = over_q;

endmodule
